// File: rtl/ycbcr2rgb_pp_if.sv
// Row-in / pixel-out bundle for ycbcr2rgb_pp.
// The master side supplies rows of 8 YCbCr pixels; the slave side returns serial RGB pixels.
interface ycbcr2rgb_pp_if;
    logic        enable;
    logic [23:0] data_in [7:0];
    logic        in_ready;
    logic [23:0] data_out;
    logic        enable_out;
    logic        overflow;

    modport master (
        output enable,
        output data_in,
        input  in_ready,
        input  data_out,
        input  enable_out,
        input  overflow
    );

    modport slave (
        input  enable,
        input  data_in,
        output in_ready,
        output data_out,
        output enable_out,
        output overflow
    );
endinterface

// File: rtl/ycbcr2rgb_pp.sv
// Ping-pong row buffer feeding a 3-stage YCbCr->RGB converter, one pixel per clock out.
// Define YCBCR2RGB_SAT_EN to clamp results to 0..255; otherwise they wrap to 8 bits.
module ycbcr2rgb_pp (
    input  logic          clk,
    input  logic          rst,
    ycbcr2rgb_pp_if.slave io
);

`ifdef YCBCR2RGB_SAT_EN
    localparam int RW = 12;
`else
    localparam int RW = 8;
`endif

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  full_q, full_d;
    logic        wptr_q, wptr_d;
    logic        rptr_q, rptr_d;
    logic        ovf_q, ovf_d;
    logic        in_ready, wr_en, issue;

    logic [23:0] rd_pix [8];
    logic [23:0] pix;

    logic signed [23:0] cb_off, cr_off;
    logic        v1_q, v1_d;
    logic [7:0]  y1_q, y1_d;
    logic signed [23:0] mr_q, mr_d, mgb_q, mgb_d, mgr_q, mgr_d, mb_q, mb_d;

    logic signed [24:0] y_ext, sr, sg, sb;
    logic        v2_q, v2_d;
    logic signed [RW-1:0] r2_q, r2_d, g2_q, g2_d, b2_q, b2_d;

    logic        en_q, en_d;
    logic [23:0] dout_q, dout_d;

    assign in_ready = ~(full_q[0] & full_q[1]);
    assign wr_en    = io.enable & in_ready;

    // Each pixel column owns a two-entry store, one entry per bank.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bank
            logic [23:0] mem_q [2];
            always_ff @(posedge clk) begin
                if (wr_en) begin
                    mem_q[wptr_q] <= io.data_in[gi];
                end
            end
            assign rd_pix[gi] = mem_q[rptr_q];
        end
    endgenerate

    assign pix = rd_pix[cnt_q];

    // Bank bookkeeping and reader FSM next state; the freed bank only becomes
    // writable after the edge that clears its flag, since in_ready uses full_q.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        full_d  = full_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        ovf_d   = ovf_q;
        issue   = 1'b0;
        if (io.enable && !in_ready) begin
            ovf_d = 1'b1;
        end
        if (wr_en) begin
            full_d[wptr_q] = 1'b1;
            wptr_d         = ~wptr_q;
        end
        case (state_q)
            IDLE: begin
                if (full_q[rptr_q]) begin
                    state_d = DRAIN;
                    cnt_d   = 3'd0;
                end
            end
            DRAIN: begin
                issue = 1'b1;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    full_d[rptr_q] = 1'b0;
                    rptr_d         = ~rptr_q;
                    if (!full_q[~rptr_q]) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cr_off = $signed({16'd0, pix[23:16]}) - 24'sd128;
        cb_off = $signed({16'd0, pix[15:8]}) - 24'sd128;
        v1_d   = issue;
        y1_d   = pix[7:0];
        mr_d   = cr_off * 24'sd11485;
        mgb_d  = cb_off * 24'sd2819;
        mgr_d  = cr_off * 24'sd5850;
        mb_d   = cb_off * 24'sd14516;
    end

    // Y is aligned to the 13 fractional bits; +4096 rounds before the shift.
    always_comb begin
        y_ext = $signed({4'd0, y1_q, 13'd0});
        sr    = y_ext + $signed({mr_q[23], mr_q}) + 25'sd4096;
        sg    = y_ext - $signed({mgb_q[23], mgb_q}) - $signed({mgr_q[23], mgr_q}) + 25'sd4096;
        sb    = y_ext + $signed({mb_q[23], mb_q}) + 25'sd4096;
        v2_d  = v1_q;
        r2_d  = RW'(sr >>> 13);
        g2_d  = RW'(sg >>> 13);
        b2_d  = RW'(sb >>> 13);
    end

`ifdef YCBCR2RGB_SAT_EN
    function automatic logic [7:0] sat8(input logic signed [11:0] v);
        if (v < 0) begin
            return 8'h00;
        end else if (v > 255) begin
            return 8'hFF;
        end
        return v[7:0];
    endfunction
`endif

    always_comb begin
        en_d   = v2_q;
        dout_d = dout_q;
        if (v2_q) begin
`ifdef YCBCR2RGB_SAT_EN
            dout_d = {sat8(b2_q), sat8(g2_q), sat8(r2_q)};
`else
            dout_d = {b2_q, g2_q, r2_q};
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            full_q  <= 2'b00;
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            ovf_q   <= 1'b0;
            v1_q    <= 1'b0;
            y1_q    <= 8'd0;
            mr_q    <= '0;
            mgb_q   <= '0;
            mgr_q   <= '0;
            mb_q    <= '0;
            v2_q    <= 1'b0;
            r2_q    <= '0;
            g2_q    <= '0;
            b2_q    <= '0;
            en_q    <= 1'b0;
            dout_q  <= 24'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            ovf_q   <= ovf_d;
            v1_q    <= v1_d;
            y1_q    <= y1_d;
            mr_q    <= mr_d;
            mgb_q   <= mgb_d;
            mgr_q   <= mgr_d;
            mb_q    <= mb_d;
            v2_q    <= v2_d;
            r2_q    <= r2_d;
            g2_q    <= g2_d;
            b2_q    <= b2_d;
            en_q    <= en_d;
            dout_q  <= dout_d;
        end
    end

    assign io.in_ready   = in_ready;
    assign io.data_out   = dout_q;
    assign io.enable_out = en_q;
    assign io.overflow   = ovf_q;

endmodule

// File: tb/tb_ycbcr2rgb_pp.sv
// Bench for ycbcr2rgb_pp: fixed vectors, directed corner sequences and random rows
// scored against a timing/occupancy model of the ping-pong buffer.
module tb_ycbcr2rgb_pp;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ycbcr2rgb_pp_if io();
    ycbcr2rgb_pp dut (.clk(clk), .rst(rst), .io(io));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [23:0] d;
        int          c;
    } obs_t;
    obs_t obs_q[$];
    obs_t exp_q[$];

    always @(negedge clk) begin
        if (io.enable_out === 1'b1) obs_q.push_back('{io.data_out, cyc});
    end

    typedef struct {
        logic [23:0] pix;
        logic [23:0] rgb;
    } vec_t;

    int nvec = 0;
    int nerr = 0;

    int          m_a[$];
    int          m_s[$];
    int          m_last_s = -100;
    bit          m_ovf = 1'b0;
    logic [23:0] hold_m = 24'd0;
    int          last_rst = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s at edge %0d: got %h, expected %h", nm, cyc, got, want);
        end
    endtask

    function automatic logic [7:0] fix8(input int v);
`ifdef YCBCR2RGB_SAT_EN
        if (v < 0) return 8'd0;
        if (v > 255) return 8'd255;
`endif
        return v[7:0];
    endfunction

    function automatic logic [23:0] conv(input logic [23:0] p);
        int y, cb, cr, r, g, b;
        y  = int'(p[7:0]);
        cb = int'(p[15:8]);
        cr = int'(p[23:16]);
        r = (y * 8192 + 11485 * (cr - 128) + 4096) >>> 13;
        g = (y * 8192 - 2819 * (cb - 128) - 5850 * (cr - 128) + 4096) >>> 13;
        b = (y * 8192 + 14516 * (cb - 128) + 4096) >>> 13;
        return {fix8(b), fix8(g), fix8(r)};
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one row on the next edge. A row holds a bank from the edge after it
    // is written through its drain's last-pixel edge; drains start no sooner than
    // two edges after acceptance and back-to-back drains are 8 edges apart.
    task automatic attempt_row(input logic [23:0] pix [8], input logic [23:0] ex [8]);
        int e, occ, s;
        bit rdy;
        e = cyc + 1;
        occ = 0;
        foreach (m_a[i]) if (m_a[i] < e && e <= m_s[i] + 7) occ++;
        rdy = (occ < 2);
        chk("in_ready", io.in_ready, rdy);
        for (int k = 0; k < 8; k++) io.data_in[k] = pix[k];
        io.enable = 1'b1;
        @(posedge clk);
        #1;
        io.enable = 1'b0;
        if (rdy) begin
            s = (e + 2 > m_last_s + 8) ? e + 2 : m_last_s + 8;
            m_a.push_back(e);
            m_s.push_back(s);
            m_last_s = s;
            for (int k = 0; k < 8; k++) exp_q.push_back('{ex[k], s + 2 + k});
        end else begin
            m_ovf = 1'b1;
        end
        chk("overflow", io.overflow, m_ovf);
    endtask

    task automatic check_outs();
        int tgt, n;
        tgt = cyc + 12;
        if (exp_q.size() > 0 && exp_q[exp_q.size()-1].c + 4 > tgt) tgt = exp_q[exp_q.size()-1].c + 4;
        while (cyc < tgt) idle(1);
        chk("out_count", obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk("pix_data", obs_q[i].d, exp_q[i].d);
            chk("pix_edge", obs_q[i].c, exp_q[i].c);
        end
        if (exp_q.size() > 0 && exp_q[exp_q.size()-1].c >= last_rst) hold_m = exp_q[exp_q.size()-1].d;
        chk("idle_enable_out", io.enable_out, 1'b0);
        chk("hold_data_out", io.data_out, hold_m);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        obs_t keep[$];
        rst = 1'b0;
        #1;
        chk("rst_enable_out", io.enable_out, 1'b0);
        chk("rst_in_ready", io.in_ready, 1'b1);
        chk("rst_overflow", io.overflow, 1'b0);
        chk("rst_data_out", io.data_out, 24'd0);
        foreach (exp_q[i]) if (exp_q[i].c < cyc) keep.push_back(exp_q[i]);
        exp_q = keep;
        m_a.delete();
        m_s.delete();
        m_last_s = -100;
        m_ovf = 1'b0;
        hold_m = 24'd0;
        last_rst = cyc;
        idle(2);
        rst = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[5];
        logic [23:0] pix [8];
        logic [23:0] ex [8];
        int          a;

        tbl[0] = '{24'h808080, 24'h808080};
        tbl[4] = '{24'h808064, 24'h646464};
`ifdef YCBCR2RGB_SAT_EN
        tbl[1] = '{24'hFF80FF, 24'hFFA4FF};
        tbl[2] = '{24'h000000, 24'h008700};
        tbl[3] = '{24'h80FF00, 24'hE10000};
`else
        tbl[1] = '{24'hFF80FF, 24'hFFA4B1};
        tbl[2] = '{24'h000000, 24'h1D874D};
        tbl[3] = '{24'h80FF00, 24'hE1D400};
`endif

        io.enable = 1'b0;
        for (int k = 0; k < 8; k++) io.data_in[k] = 24'd0;

        // Held in reset.
        idle(3);
        chk("rst_enable_out", io.enable_out, 1'b0);
        chk("rst_in_ready", io.in_ready, 1'b1);
        chk("rst_overflow", io.overflow, 1'b0);
        chk("rst_data_out", io.data_out, 24'd0);
        rst = 1'b1;
        idle(2);

        // Fixed vectors, one uniform row each.
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 8; k++) begin
                pix[k] = tbl[i].pix;
                ex[k]  = tbl[i].rgb;
            end
            attempt_row(pix, ex);
            check_outs();
        end

        // Rows every 8 cycles: gray ramp 0..31 must stream without a gap.
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 8; k++) begin
                pix[k] = {8'h80, 8'h80, 8'(r * 8 + k)};
                ex[k]  = {3{8'(r * 8 + k)}};
            end
            attempt_row(pix, ex);
            if (r < 3) idle(7);
        end
        check_outs();

        // Three rows on consecutive edges: third dropped, overflow sticks.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 8; k++) begin
                pix[k] = 24'($urandom);
                ex[k]  = conv(pix[k]);
            end
            attempt_row(pix, ex);
        end
        check_outs();
        idle(20);
        chk("overflow_sticky", io.overflow, 1'b1);
        do_reset();
        idle(1);

        // Reset in the middle of a drain, then a fresh row.
        for (int k = 0; k < 8; k++) begin
            pix[k] = 24'($urandom);
            ex[k]  = conv(pix[k]);
        end
        attempt_row(pix, ex);
        a = m_a[m_a.size()-1];
        while (cyc < a + 5) idle(1);
        do_reset();
        check_outs();
        for (int k = 0; k < 8; k++) begin
            pix[k] = 24'($urandom);
            ex[k]  = conv(pix[k]);
        end
        attempt_row(pix, ex);
        check_outs();

        // Random rows with random gaps, including overrun.
        repeat (40) begin
            for (int k = 0; k < 8; k++) begin
                pix[k] = 24'($urandom);
                ex[k]  = conv(pix[k]);
            end
            attempt_row(pix, ex);
            idle($urandom_range(0, 12));
        end
        check_outs();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
